// File: rtl/i2c_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_init_seq
//  Purpose  : Boot-time command sequencer for an I2C write master. Walks a
//             register table held in an external synchronous ROM and issues
//             one {device, reg_addr, reg_data} write per entry over a
//             valid/ready handshake. Starts on its own after a power-up
//             wait and can be re-run from DONE with a start pulse.
//  Ports    : clk        system clock
//             reset      asynchronous, active-low reset
//             start      re-run pulse, honoured only in DONE
//             busy       high from reset release until the table completes
//             done       high while in DONE
//             rom_addr   registered table index (ROM data 1 cycle later)
//             rom_data   {reg_addr[15:8], reg_data[7:0]}; 16'hFFFF ends table
//             i2c_valid  write request to the master
//             i2c_ready  master accepting
//             i2c_device constant device byte (DEVICE)
//             i2c_addr   register address, held while i2c_valid is high
//             i2c_data   register data, held while i2c_valid is high
//             cmd_count  writes issued in the current run
//  Options  : I2C_INIT_SEQ_DELAY_EN - entries with reg_addr 8'hFE become
//             wait commands of reg_data*DELAY_UNIT cycles instead of writes.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_init_seq #(
  parameter int         NUM_CMDS       = 32,
  parameter int         IDX_W          = 5,
  parameter logic [7:0] DEVICE         = 8'h34,
  parameter int         POWERUP_CYCLES = 100000,
  parameter int         DELAY_UNIT     = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] rom_addr,
  input  logic [15:0]      rom_data,
  output logic             i2c_valid,
  input  logic             i2c_ready,
  output logic [7:0]       i2c_device,
  output logic [7:0]       i2c_addr,
  output logic [7:0]       i2c_data,
  output logic [IDX_W:0]   cmd_count
);

  // Power-up counter is wide enough to hold POWERUP_CYCLES itself.
  localparam int c_PU_W = (POWERUP_CYCLES < 1) ? 1 : $clog2(POWERUP_CYCLES + 1);
  localparam logic [c_PU_W-1:0] c_PU_LAST  = c_PU_W'(POWERUP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_CMDS - 1);
  localparam logic [15:0]       c_END_MARK = 16'hFFFF;

  localparam logic [2:0] c_ST_POWERUP = 3'd0;
  localparam logic [2:0] c_ST_FETCH   = 3'd1;
  localparam logic [2:0] c_ST_DECODE  = 3'd2;
  localparam logic [2:0] c_ST_SEND    = 3'd3;
  localparam logic [2:0] c_ST_DONE    = 3'd4;
`ifdef I2C_INIT_SEQ_DELAY_EN
  localparam logic [2:0] c_ST_DELAY   = 3'd5;
  localparam logic [7:0] c_DLY_OPCODE = 8'hFE;
  // Must hold the longest wait, 255 ticks of DELAY_UNIT cycles.
  localparam int         c_DLY_W      = $clog2(255 * DELAY_UNIT + 1);
`endif

  // Parameter sanity, evaluated at elaboration only.
  if ((2 ** IDX_W) < NUM_CMDS || NUM_CMDS < 1) begin : g_bad_table_size
    $error("i2c_init_seq: IDX_W too narrow for NUM_CMDS, or NUM_CMDS < 1");
  end
  if (POWERUP_CYCLES < 1 || DELAY_UNIT < 1) begin : g_bad_timing
    $error("i2c_init_seq: POWERUP_CYCLES and DELAY_UNIT must be >= 1");
  end

  logic [2:0]        r_state;
  logic [c_PU_W-1:0] r_pu_cnt;
  logic [IDX_W-1:0]  r_rom_addr;
  logic [IDX_W:0]    r_cmd_count;
  logic              r_valid;
  logic [7:0]        r_addr;
  logic [7:0]        r_data;
`ifdef I2C_INIT_SEQ_DELAY_EN
  logic [c_DLY_W-1:0] r_dly_cnt;
`endif

  // Current entry is the last table slot: the next advance ends the run.
  logic w_last;
  assign w_last = (r_rom_addr == c_LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_ST_POWERUP;
      r_pu_cnt    <= '0;
      r_rom_addr  <= '0;
      r_cmd_count <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
`ifdef I2C_INIT_SEQ_DELAY_EN
      r_dly_cnt   <= '0;
`endif
    end else begin
      case (r_state)
        c_ST_POWERUP: begin
          r_pu_cnt <= r_pu_cnt + c_PU_W'(1);
          if (r_pu_cnt == c_PU_LAST) begin
            r_rom_addr <= '0;
            r_state    <= c_ST_FETCH;
          end
        end

        // rom_addr is already on the ROM; this cycle covers its latency.
        c_ST_FETCH: begin
          r_state <= c_ST_DECODE;
        end

        c_ST_DECODE: begin
          if (rom_data == c_END_MARK) begin
            r_state <= c_ST_DONE;
          end
`ifdef I2C_INIT_SEQ_DELAY_EN
          else if (rom_data[15:8] == c_DLY_OPCODE) begin
            r_dly_cnt <= c_DLY_W'(32'(rom_data[7:0]) * DELAY_UNIT);
            r_state   <= c_ST_DELAY;
          end
`endif
          else begin
            r_addr  <= rom_data[15:8];
            r_data  <= rom_data[7:0];
            r_valid <= 1'b1;
            r_state <= c_ST_SEND;
          end
        end

        // Request stays up with a frozen payload until the master takes it.
        c_ST_SEND: begin
          if (r_valid && i2c_ready) begin
            r_valid     <= 1'b0;
            r_cmd_count <= r_cmd_count + (IDX_W + 1)'(1);
            if (w_last) begin
              r_rom_addr <= '0;
              r_state    <= c_ST_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + IDX_W'(1);
              r_state    <= c_ST_FETCH;
            end
          end
        end

`ifdef I2C_INIT_SEQ_DELAY_EN
        // Count of N lasts N+1 cycles, so a zero-length wait still takes one.
        c_ST_DELAY: begin
          if (r_dly_cnt == '0) begin
            if (w_last) begin
              r_rom_addr <= '0;
              r_state    <= c_ST_DONE;
            end else begin
              r_rom_addr <= r_rom_addr + IDX_W'(1);
              r_state    <= c_ST_FETCH;
            end
          end else begin
            r_dly_cnt <= r_dly_cnt - c_DLY_W'(1);
          end
        end
`endif

        // Re-run skips the power-up wait.
        c_ST_DONE: begin
          if (start) begin
            r_rom_addr  <= '0;
            r_cmd_count <= '0;
            r_state     <= c_ST_FETCH;
          end
        end

        default: begin
          r_state <= c_ST_POWERUP;
        end
      endcase
    end
  end

  assign busy       = (r_state != c_ST_DONE);
  assign done       = (r_state == c_ST_DONE);
  assign rom_addr   = r_rom_addr;
  assign i2c_valid  = r_valid;
  assign i2c_device = DEVICE;
  assign i2c_addr   = r_addr;
  assign i2c_data   = r_data;
  assign cmd_count  = r_cmd_count;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_init_seq
//  Purpose  : Self-checking bench for i2c_init_seq. A synchronous ROM model
//             holds the table; a master model drives i2c_ready; a reference
//             model derives the expected write list and acceptance spacing
//             straight from the table contents.
//  Options  : I2C_INIT_SEQ_DELAY_EN changes how 8'hFE entries are expected.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_init_seq;
  localparam int NUM_CMDS = 32;
  localparam int IDX_W    = 5;
  localparam int PU       = 10;
  localparam int DU       = 4;
`ifdef I2C_INIT_SEQ_DELAY_EN
  localparam bit C_DLY = 1'b1;
`else
  localparam bit C_DLY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             busy, done;
  logic [IDX_W-1:0] rom_addr;
  logic [15:0]      rom_data = '0;
  logic             i2c_valid;
  logic             i2c_ready = 1'b1;
  logic [7:0]       i2c_device, i2c_addr, i2c_data;
  logic [IDX_W:0]   cmd_count;

  i2c_init_seq #(
    .NUM_CMDS(NUM_CMDS), .IDX_W(IDX_W), .DEVICE(8'h34),
    .POWERUP_CYCLES(PU), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .i2c_valid(i2c_valid),
    .i2c_ready(i2c_ready), .i2c_device(i2c_device), .i2c_addr(i2c_addr),
    .i2c_data(i2c_data), .cmd_count(cmd_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data valid one cycle after the address.
  logic [15:0] mem [NUM_CMDS];
  always @(posedge clk) rom_data <= mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void check(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endfunction

  // Reference model: the writes a run must produce, in order.
  logic [15:0] exp_q [$];
  int          exp_n;
  function automatic void build_model();
    exp_q.delete();
    exp_n = 0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (mem[i] == 16'hFFFF) break;
      if (C_DLY && mem[i][15:8] == 8'hFE) continue;
      exp_q.push_back(mem[i]);
      exp_n++;
    end
  endfunction

  // Master model and scoreboard.
  int   mode = 0;       // 0: ready=1, 1: random ready, 2: ready low 50 cycles
  int   hold = 0;
  bit   chk_en = 1'b0;
  bit   pv = 1'b0, pacc = 1'b0;
  int   acc_cyc [$];
  always @(negedge clk) begin
    case (mode)
      0:       i2c_ready = 1'b1;
      1:       i2c_ready = ($urandom_range(0, 2) != 0);
      default: i2c_ready = (hold >= 50);
    endcase
    if (i2c_valid) hold = hold + 1;
    else           hold = 0;
    if (chk_en) begin
      if (pv && !pacc) check("valid_dropped_unaccepted", i2c_valid, 1'b1);
      if (i2c_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, no write expected", i2c_addr, i2c_data);
        end else begin
          check("payload_addr", i2c_addr, exp_q[0][15:8]);
          check("payload_data", i2c_data, exp_q[0][7:0]);
          check("device_byte", i2c_device, 8'h34);
        end
      end
      pacc = i2c_valid && i2c_ready;
      if (pacc) begin
        acc_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      pv = i2c_valid;
    end else begin
      pv   = 1'b0;
      pacc = 1'b0;
    end
  end

  // Expected spacing with ready tied high: 3 cycles per write, plus
  // FETCH+DECODE+(n*DU+1) DELAY cycles per wait entry in between.
  task automatic check_gaps();
    int exp_g [$];
    int g;
    bit seen;
    g = 0;
    seen = 1'b0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      if (mem[i] == 16'hFFFF) break;
      if (C_DLY && mem[i][15:8] == 8'hFE) begin
        g += 3 + int'(mem[i][7:0]) * DU;
      end else begin
        if (seen) exp_g.push_back(g + 3);
        seen = 1'b1;
        g = 0;
      end
    end
    check("accept_count", acc_cyc.size(), exp_g.size() + int'(seen));
    if (acc_cyc.size() == exp_g.size() + int'(seen))
      for (int k = 0; k < exp_g.size(); k++)
        check("accept_gap", acc_cyc[k+1] - acc_cyc[k], exp_g[k]);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (i2c_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("valid_reached", i2c_valid, 1'b1);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_end();
    for (int i = 0; i < NUM_CMDS; i++) mem[i] = 16'hFFFF;
  endtask

  task automatic fill_full();
    logic [15:0] r;
    for (int i = 0; i < NUM_CMDS; i++) begin
      do r = 16'($urandom); while (r == 16'hFFFF || r[15:8] == 8'hFE);
      mem[i] = r;
    end
  endtask

  typedef struct {
    logic [15:0] e0, e1, e2, e3;
    int          cnt;
    logic        first_wr;
    logic [7:0]  a0, d0;
  } vec_t;
  vec_t vt [6];

  initial begin
    vt[0] = '{16'h1234, 16'h5678, 16'hFFFF, 16'h0000, 2, 1'b1, 8'h12, 8'h34};
    vt[1] = '{16'hFFFF, 16'h1111, 16'h2222, 16'h3333, 0, 1'b0, 8'h00, 8'h00};
    vt[2] = '{16'hA55A, 16'h0000, 16'hFFFE, 16'hFFFF, 3, 1'b1, 8'hA5, 8'h5A};
    vt[3] = '{16'h1234, 16'hFE03, 16'h5678, 16'hFFFF, C_DLY ? 2 : 3, 1'b1, 8'h12, 8'h34};
    vt[4] = '{16'hFE00, 16'hABCD, 16'hFFFF, 16'h0000, C_DLY ? 1 : 2, !C_DLY, 8'hFE, 8'h00};
    vt[5] = '{16'h0001, 16'h0203, 16'h0405, 16'h0607, 4, 1'b1, 8'h00, 8'h01};

    // ---- reset state ----
    fill_end();
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_valid", i2c_valid, 1'b0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_cmd_count", cmd_count, 0);
    check("rst_addr", i2c_addr, 0);
    check("rst_data", i2c_data, 0);

    // ---- first run: 10-cycle wait, then FETCH, DECODE ----
    build_model();
    acc_cyc.delete();
    chk_en = 1'b1;
    reset  = 1'b1;
    repeat (11) @(negedge clk);
    check("valid_before_cycle12", i2c_valid, 1'b0);
    @(negedge clk);
    check("valid_at_cycle12", i2c_valid, 1'b1);
    check("first_addr", i2c_addr, 8'h12);
    check("first_data", i2c_data, 8'h34);
    wait_done(500);
    check("run1_cmd_count", cmd_count, 2);
    check("run1_busy", busy, 1'b0);
    check("run1_queue_drained", exp_q.size(), 0);
    check_gaps();

    // ---- table vectors, each re-run from DONE ----
    for (int v = 0; v < 6; v++) begin
      fill_end();
      mem[0] = vt[v].e0; mem[1] = vt[v].e1; mem[2] = vt[v].e2; mem[3] = vt[v].e3;
      build_model();
      acc_cyc.delete();
      pulse_start();
      check("rerun_busy", busy, 1'b1);
      @(negedge clk);
      check("rerun_fetch_no_valid", i2c_valid, 1'b0);
      @(negedge clk);
      check("rerun_no_powerup_wait", i2c_valid, vt[v].first_wr);
      if (vt[v].first_wr) begin
        check("vec_first_addr", i2c_addr, vt[v].a0);
        check("vec_first_data", i2c_data, vt[v].d0);
      end
      wait_done(500);
      check("vec_cmd_count", cmd_count, vt[v].cnt);
      check("vec_queue_drained", exp_q.size(), 0);
      check_gaps();
    end

    // ---- full table without end marker: wraps to DONE ----
    for (int m = 0; m < 2; m++) begin
      fill_full();
      build_model();
      acc_cyc.delete();
      mode = m;
      pulse_start();
      wait_done(3000);
      check("full_cmd_count", cmd_count, 32);
      check("full_rom_addr_wrap", rom_addr, 0);
      check("full_queue_drained", exp_q.size(), 0);
      if (m == 0) check_gaps();
    end

    // ---- slow master, start ignored during SEND ----
    fill_end();
    mem[0] = 16'hABCD;
    build_model();
    acc_cyc.delete();
    mode = 2;
    pulse_start();
    wait_valid(20);
    check("hold_addr", i2c_addr, 8'hAB);
    check("hold_data", i2c_data, 8'hCD);
    repeat (10) @(negedge clk);
    pulse_start();
    check("send_start_ignored_count", cmd_count, 0);
    check("send_start_ignored_valid", i2c_valid, 1'b1);
    check("send_start_ignored_busy", busy, 1'b1);
    wait_done(200);
    check("hold_cmd_count", cmd_count, 1);
    check("hold_single_accept", acc_cyc.size(), 1);

    // ---- wait entries (ordinary writes when the option is off) ----
    fill_end();
    mem[0] = 16'h1111; mem[1] = 16'hFE03; mem[2] = 16'h2222;
    mem[3] = 16'hFE00; mem[4] = 16'h3333;
    build_model();
    acc_cyc.delete();
    mode = 0;
    pulse_start();
    wait_done(500);
    check("delay_cmd_count", cmd_count, C_DLY ? 3 : 5);
    check_gaps();

    // ---- randomized tables against the model ----
    for (int it = 0; it < 12; it++) begin
      logic [15:0] r;
      int          pos;
      for (int i = 0; i < NUM_CMDS; i++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 7) == 0) r = {8'hFE, 8'($urandom_range(0, 3))};
        mem[i] = r;
      end
      pos = $urandom_range(0, 40);
      if (pos < NUM_CMDS) mem[pos] = 16'hFFFF;
      build_model();
      acc_cyc.delete();
      mode = 1;
      pulse_start();
      wait_done(5000);
      check("rand_cmd_count", cmd_count, exp_n);
      check("rand_queue_drained", exp_q.size(), 0);
    end

    // ---- reset while a request is pending ----
    fill_full();
    build_model();
    mode = 2;
    pulse_start();
    begin
      int k;
      k = 0;
      while (!(cmd_count == 3 && i2c_valid === 1'b1) && k < 1000) begin
        @(negedge clk);
        k++;
      end
    end
    check("midtable_valid_pending", i2c_valid, 1'b1);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("async_rst_valid", i2c_valid, 1'b0);
    check("async_rst_busy", busy, 1'b1);
    check("async_rst_cmd_count", cmd_count, 0);
    check("async_rst_rom_addr", rom_addr, 0);
    repeat (2) @(negedge clk);
    build_model();
    acc_cyc.delete();
    mode = 0;
    chk_en = 1'b1;
    reset = 1'b1;
    repeat (11) @(negedge clk);
    check("restart_valid_before_12", i2c_valid, 1'b0);
    @(negedge clk);
    check("restart_valid_at_12", i2c_valid, 1'b1);
    wait_done(500);
    check("restart_cmd_count", cmd_count, exp_n);
    check("restart_queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
